// File: rtl/io_peripheral_responder_pkg.sv
// ----------------------------------------------------------------------------
// io_peripheral_responder_pkg
// Shared constants for the IO peripheral responder: core command codes,
// response codes, response-stage FSM states and the STATUS word layout.
// No ports (package).
// ----------------------------------------------------------------------------
package io_peripheral_responder_pkg;

   typedef enum logic [1:0] {
      CMD_NOP    = 2'b00,
      CMD_WRITE  = 2'b01,
      CMD_READ   = 2'b10,
      CMD_STATUS = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE  = 2'b00,
      RESP_ACK   = 2'b01,
      RESP_DATA  = 2'b10,
      RESP_ERROR = 2'b11
   } resp_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   // STATUS payload layout; every bit above STATUS_W-1 reads as zero.
   localparam int STATUS_TX_COUNT_LSB = 0;
   localparam int STATUS_RX_COUNT_LSB = 8;
   localparam int STATUS_COUNT_W      = 8;
   localparam int STATUS_TX_FULL_BIT  = 16;
   localparam int STATUS_RX_EMPTY_BIT = 17;
   localparam int STATUS_W            = 18;

   function automatic logic [STATUS_W-1:0] status_word(
      input logic [STATUS_COUNT_W-1:0] tx_count,
      input logic [STATUS_COUNT_W-1:0] rx_count,
      input logic                      tx_full,
      input logic                      rx_empty
   );
      logic [STATUS_W-1:0] w;
      w = '0;
      w[STATUS_TX_COUNT_LSB +: STATUS_COUNT_W] = tx_count;
      w[STATUS_RX_COUNT_LSB +: STATUS_COUNT_W] = rx_count;
      w[STATUS_TX_FULL_BIT]                    = tx_full;
      w[STATUS_RX_EMPTY_BIT]                   = rx_empty;
      return w;
   endfunction

endpackage

// File: rtl/io_peripheral_responder_if.sv
// ----------------------------------------------------------------------------
// io_peripheral_responder_if
// Bundles the core command/response bus and both host-side FIFO handshakes.
//   slave  : the responder (takes commands, drives responses, TX drain,
//            RX fill ready)
//   master : the core + host side driving the responder
// ----------------------------------------------------------------------------
interface io_peripheral_responder_if #(
   parameter int DATA_WIDTH = 32
);
   // core -> peripheral command
   logic [1:0]            to_peripheral;
   logic [DATA_WIDTH-1:0] to_peripheral_data;
   logic                  to_peripheral_valid;
   // peripheral -> core response
   logic [1:0]            from_peripheral;
   logic [DATA_WIDTH-1:0] from_peripheral_data;
   logic                  from_peripheral_valid;
   // host drain of the TX FIFO
   logic [DATA_WIDTH-1:0] host_out_data;
   logic                  host_out_valid;
   logic                  host_out_ready;
   // host fill of the RX FIFO
   logic [DATA_WIDTH-1:0] host_in_data;
   logic                  host_in_valid;
   logic                  host_in_ready;

   modport slave (
      input  to_peripheral, to_peripheral_data, to_peripheral_valid,
      input  host_out_ready, host_in_data, host_in_valid,
      output from_peripheral, from_peripheral_data, from_peripheral_valid,
      output host_out_data, host_out_valid, host_in_ready
   );

   modport master (
      output to_peripheral, to_peripheral_data, to_peripheral_valid,
      output host_out_ready, host_in_data, host_in_valid,
      input  from_peripheral, from_peripheral_data, from_peripheral_valid,
      input  host_out_data, host_out_valid, host_in_ready
   );
endinterface

// File: rtl/io_peripheral_responder_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (first-word-fall-through view).
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : remove head entry (ignored when empty)
//   head                : current head entry (undefined when empty)
//   full, empty, count  : occupancy at the start of the current cycle
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Explicit wrap keeps the pointer inside 0..FIFO_DEPTH-1 for every depth.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately left out of reset; the pointers define
   // which entries are live, so resetting the array would only cost area.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/io_peripheral_responder.sv
// ----------------------------------------------------------------------------
// io_peripheral_responder
// Services core commands (NOP/WRITE/READ/STATUS) against a TX FIFO drained by
// the host and an RX FIFO filled by the host; one registered response per
// non-NOP command, one cycle after acceptance.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset; also masks any pending response
//   bus   : io_peripheral_responder_if.slave (command, response, host I/O)
// ----------------------------------------------------------------------------
module io_peripheral_responder
   import io_peripheral_responder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   io_peripheral_responder_if.slave  bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic [CNT_W-1:0]      w_tx_count, w_rx_count;
   logic [DATA_WIDTH-1:0] w_tx_head, w_rx_head;
   logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   cmd_e                  w_cmd;
   logic                  w_cmd_active;

   state_e                r_state, w_state_next;
   resp_e                 r_resp, w_resp_next;
   logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_next;

   assign w_cmd        = cmd_e'(bus.to_peripheral);
   assign w_cmd_active = bus.to_peripheral_valid && (w_cmd != CMD_NOP);

   // Full/empty come straight from registered FIFO state, so a host transfer
   // in the same cycle never changes the command's outcome.
   assign w_tx_push = bus.to_peripheral_valid && (w_cmd == CMD_WRITE) && !w_tx_full;
   assign w_rx_pop  = bus.to_peripheral_valid && (w_cmd == CMD_READ) && !w_rx_empty;
   assign w_tx_pop  = !w_tx_empty && bus.host_out_ready;
   assign w_rx_push = bus.host_in_valid && !w_rx_full;

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_tx_push),
      .push_data (bus.to_peripheral_data),
      .pop       (w_tx_pop),
      .head      (w_tx_head),
      .full      (w_tx_full),
      .empty     (w_tx_empty),
      .count     (w_tx_count)
   );

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_rx_push),
      .push_data (bus.host_in_data),
      .pop       (w_rx_pop),
      .head      (w_rx_head),
      .full      (w_rx_full),
      .empty     (w_rx_empty),
      .count     (w_rx_count)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_next     = ST_IDLE;
      w_resp_next      = RESP_NONE;
      w_resp_data_next = '0;
      if (w_cmd_active) begin
         w_state_next = ST_RESP;
         case (w_cmd)
            CMD_WRITE: w_resp_next = w_tx_full ? RESP_ERROR : RESP_ACK;
            CMD_READ: begin
               if (w_rx_empty) begin
                  w_resp_next = RESP_ERROR;
               end else begin
                  w_resp_next      = RESP_DATA;
                  w_resp_data_next = w_rx_head;
               end
            end
            CMD_STATUS: begin
               w_resp_next      = RESP_DATA;
               w_resp_data_next = DATA_WIDTH'(status_word(8'(w_tx_count), 8'(w_rx_count),
                                                          w_tx_full, w_rx_empty));
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_resp      <= RESP_NONE;
         r_resp_data <= '0;
      end else begin
         r_state     <= w_state_next;
         r_resp      <= w_resp_next;
         r_resp_data <= w_resp_data_next;
      end
   end

   // A response still pending when reset rises is dropped immediately rather
   // than shown for its last cycle.
   assign bus.from_peripheral_valid = (r_state == ST_RESP) && !reset;
   assign bus.from_peripheral       = reset ? RESP_NONE : r_resp;
   assign bus.from_peripheral_data  = reset ? '0 : r_resp_data;

   assign bus.host_out_valid = !w_tx_empty;
   assign bus.host_out_data  = w_tx_head;
   assign bus.host_in_ready  = !w_rx_full;

endmodule

// File: tb/tb_io_peripheral_responder.sv
// ----------------------------------------------------------------------------
// tb_io_peripheral_responder
// Drives directed and random traffic into io_peripheral_responder and checks
// it against a queue-based behavioural model of the two FIFOs and the
// command rules.
// ----------------------------------------------------------------------------
module tb_io_peripheral_responder;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, ST = 2'b11;
   localparam logic [1:0] R_NONE = 2'b00, R_ACK = 2'b01, R_DATA = 2'b10, R_ERR = 2'b11;

   logic clock;
   logic reset;

   io_peripheral_responder_if #(.DATA_WIDTH(DW)) tif ();

   io_peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (tif.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, committed just after each rising edge.
   logic [DW-1:0] tx_q[$];
   logic [DW-1:0] rx_q[$];
   bit            exp_valid;
   logic [1:0]    exp_code;
   logic [DW-1:0] exp_data;
   bit            chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, predict the edge from queue contents at the
   // start of the cycle, wait for the edge, then commit the prediction.
   task automatic step(input bit rst, input logic [1:0] cmd, input logic [DW-1:0] d,
                       input bit v, input bit hiv, input logic [DW-1:0] hid, input bit hor);
      bit            n_valid, tx_pop, tx_push, rx_pop, rx_push;
      logic [1:0]    n_code;
      logic [DW-1:0] n_data;
      int            tx_n, rx_n;
      reset                   = rst;
      tif.to_peripheral       = cmd;
      tif.to_peripheral_data  = d;
      tif.to_peripheral_valid = v;
      tif.host_in_valid       = hiv;
      tif.host_in_data        = hid;
      tif.host_out_ready      = hor;

      tx_n    = tx_q.size();
      rx_n    = rx_q.size();
      n_valid = 1'b0;
      n_code  = R_NONE;
      n_data  = '0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      tx_pop  = hor && (tx_n > 0);
      rx_push = hiv && (rx_n < DEPTH);
      if (v && cmd != NOP) begin
         n_valid = 1'b1;
         case (cmd)
            WR: if (tx_n < DEPTH) begin tx_push = 1'b1; n_code = R_ACK; end
                else n_code = R_ERR;
            RD: if (rx_n > 0) begin rx_pop = 1'b1; n_code = R_DATA; n_data = rx_q[0]; end
                else n_code = R_ERR;
            default: begin
               n_code = R_DATA;
               n_data = 32'(tx_n) | (32'(rx_n) << 8)
                      | ((tx_n == DEPTH) ? 32'h0001_0000 : 32'h0)
                      | ((rx_n == 0)     ? 32'h0002_0000 : 32'h0);
            end
         endcase
      end

      @(posedge clock);
      #1;
      if (rst) begin
         tx_q.delete();
         rx_q.delete();
         exp_valid = 1'b0;
         exp_code  = R_NONE;
         exp_data  = '0;
      end else begin
         if (tx_pop)  void'(tx_q.pop_front());
         if (tx_push) tx_q.push_back(d);
         if (rx_pop)  void'(rx_q.pop_front());
         if (rx_push) rx_q.push_back(hid);
         exp_valid = n_valid;
         exp_code  = n_code;
         exp_data  = n_data;
      end
      chk_en = 1'b1;
   endtask

   // Compare process: mid-cycle, DUT outputs against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("resp_valid", 64'(tif.from_peripheral_valid), reset ? 64'd0 : 64'(exp_valid));
         check("resp_code",  64'(tif.from_peripheral),       reset ? 64'd0 : 64'(exp_code));
         check("resp_data",  64'(tif.from_peripheral_data),  reset ? 64'd0 : 64'(exp_data));
         check("hout_valid", 64'(tif.host_out_valid),        64'(tx_q.size() > 0));
         if (tx_q.size() > 0)
            check("hout_data", 64'(tif.host_out_data), 64'(tx_q[0]));
         check("hin_ready",  64'(tif.host_in_ready),         64'(rx_q.size() < DEPTH));
      end
   end

   task automatic do_reset();
      step(1, NOP, '0, 0, 0, '0, 0);
      step(1, NOP, '0, 0, 0, '0, 0);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_resp_valid", 64'(tif.from_peripheral_valid), 64'd0);
      check("rst_hout_valid", 64'(tif.host_out_valid), 64'd0);
      check("rst_hin_ready",  64'(tif.host_in_ready), 64'd1);

      // Single WRITE
      step(0, NOP, '0, 0, 0, '0, 0);
      step(0, WR, 32'hDEAD_BEEF, 1, 0, '0, 0);
      check("wr_valid",     64'(tif.from_peripheral_valid), 64'd1);
      check("wr_code",      64'(tif.from_peripheral), 64'(R_ACK));
      check("wr_data",      64'(tif.from_peripheral_data), 64'd0);
      check("wr_hout_v",    64'(tif.host_out_valid), 64'd1);
      check("wr_hout_d",    64'(tif.host_out_data), 64'hDEAD_BEEF);
      step(0, NOP, '0, 1, 0, '0, 0);
      check("nop_valid",    64'(tif.from_peripheral_valid), 64'd0);
      check("nop_code",     64'(tif.from_peripheral), 64'(R_NONE));

      // Five back-to-back WRITEs into a depth-4 TX FIFO
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(0, WR, 32'hA0 + 32'(i), 1, 0, '0, 0);
         check("fill_valid", 64'(tif.from_peripheral_valid), 64'd1);
         check("fill_code",  64'(tif.from_peripheral), (i < 4) ? 64'(R_ACK) : 64'(R_ERR));
      end
      check("model_tx_cnt", 64'(tx_q.size()), 64'd4);
      step(0, ST, '0, 1, 0, '0, 0);
      check("full_status", 64'(tif.from_peripheral_data), 64'h0003_0004);
      for (int i = 0; i < 4; i++) begin
         check("drain_data", 64'(tif.host_out_data), 64'hA0 + 64'(i));
         step(0, NOP, '0, 0, 0, '0, 1);
      end
      check("drain_empty", 64'(tif.host_out_valid), 64'd0);

      // READ on empty RX, then two host pushes and two READs
      do_reset();
      step(0, RD, '0, 1, 0, '0, 0);
      check("rd_empty_code", 64'(tif.from_peripheral), 64'(R_ERR));
      check("rd_empty_data", 64'(tif.from_peripheral_data), 64'd0);
      step(0, NOP, '0, 0, 1, 32'h11, 0);
      step(0, NOP, '0, 0, 1, 32'h22, 0);
      step(0, RD, '0, 1, 0, '0, 0);
      check("rd1_code", 64'(tif.from_peripheral), 64'(R_DATA));
      check("rd1_data", 64'(tif.from_peripheral_data), 64'h11);
      step(0, RD, '0, 1, 0, '0, 0);
      check("rd2_code", 64'(tif.from_peripheral), 64'(R_DATA));
      check("rd2_data", 64'(tif.from_peripheral_data), 64'h22);

      // STATUS with two TX and one RX entry, then on an empty block
      do_reset();
      step(0, WR, 32'h1, 1, 0, '0, 0);
      step(0, WR, 32'h2, 1, 0, '0, 0);
      step(0, NOP, '0, 0, 1, 32'h33, 0);
      step(0, ST, '0, 1, 0, '0, 0);
      check("status_2_1", 64'(tif.from_peripheral_data), 64'h0000_0102);
      do_reset();
      step(0, ST, '0, 1, 0, '0, 0);
      check("status_empty", 64'(tif.from_peripheral_data), 64'h0002_0000);

      // TX full: host pop and core WRITE in the same cycle
      do_reset();
      for (int i = 0; i < 4; i++) step(0, WR, 32'hB0 + 32'(i), 1, 0, '0, 0);
      step(0, WR, 32'hBEEF, 1, 0, '0, 1);
      check("full_pop_code", 64'(tif.from_peripheral), 64'(R_ERR));
      step(0, ST, '0, 1, 0, '0, 0);
      check("full_pop_status", 64'(tif.from_peripheral_data), 64'h0002_0003);

      // Reset the cycle after a READ is accepted
      do_reset();
      step(0, NOP, '0, 0, 1, 32'h55, 0);
      step(0, RD, '0, 1, 0, '0, 0);
      reset = 1'b1;
      #1;
      check("rst_drop_valid", 64'(tif.from_peripheral_valid), 64'd0);
      step(1, NOP, '0, 0, 0, '0, 0);
      check("rst_drop_hout", 64'(tif.host_out_valid), 64'd0);
      check("rst_drop_hin",  64'(tif.host_in_ready), 64'd1);
      step(0, ST, '0, 1, 0, '0, 0);
      check("rst_drop_status", 64'(tif.from_peripheral_data), 64'h0002_0000);

      // Random traffic; host drain/fill rates vary per phase to reach full/empty
      for (int ph = 0; ph < 4; ph++) begin
         int hor_pct, hiv_pct;
         hor_pct = (ph == 0) ? 10 : (ph == 1) ? 90 : 50;
         hiv_pct = (ph == 2) ? 10 : (ph == 3) ? 90 : 50;
         for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 99) < 1,
                 2'($urandom_range(0, 3)),
                 $urandom,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < hiv_pct,
                 $urandom,
                 $urandom_range(0, 99) < hor_pct);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/io_peripheral_responder.md
IO_PERIPHERAL_RESPONDER -- requirements
Module: io_peripheral_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, core/peripheral data word width; values below 18 are illegal.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per FIFO; must be a power of two and at most 128.
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port to_peripheral, input, 2, core command code.
REQ-006 SHALL have port to_peripheral_data, input, DATA_WIDTH, core command payload.
REQ-007 SHALL have port to_peripheral_valid, input, 1, command present this cycle.
REQ-008 SHALL have port from_peripheral, output, 2, response code to core.
REQ-009 SHALL have port from_peripheral_data, output, DATA_WIDTH, response payload.
REQ-010 SHALL have port from_peripheral_valid, output, 1, response present this cycle.
REQ-011 SHALL have ports host_out_data (output, DATA_WIDTH), host_out_valid (output, 1) and host_out_ready (input, 1), the host-side drain of the TX FIFO.
REQ-012 SHALL have ports host_in_data (input, DATA_WIDTH), host_in_valid (input, 1) and host_in_ready (output, 1), the host-side fill of the RX FIFO.

Function
REQ-013 Command codes SHALL be 00 NOP, 01 WRITE, 10 READ and 11 STATUS.
REQ-014 Response codes SHALL be 00 NONE, 01 ACK, 10 DATA and 11 ERROR.
REQ-015 A command SHALL be accepted on every cycle in which to_peripheral_valid=1; there is no back-pressure to the core.
REQ-016 Each non-NOP command SHALL produce exactly one response one cycle after acceptance, with from_peripheral_valid high for exactly that one cycle.
REQ-017 Back-to-back commands SHALL produce back-to-back responses.
REQ-018 A NOP, or to_peripheral_valid=0, SHALL produce from_peripheral_valid=0 and from_peripheral=00 on the following cycle.
REQ-019 WRITE with the TX FIFO not full SHALL push to_peripheral_data and respond ACK with payload 0.
REQ-020 WRITE with the TX FIFO full SHALL discard the data and respond ERROR with payload 0.
REQ-021 READ with the RX FIFO not empty SHALL pop the head entry and respond DATA with that entry as payload.
REQ-022 READ with the RX FIFO empty SHALL respond ERROR with payload 0 and leave the FIFO unchanged.
REQ-023 STATUS SHALL respond DATA with payload [7:0]=TX count, [15:8]=RX count, [16]=TX full, [17]=RX empty, and all other bits 0; counts are those sampled in the accept cycle.
REQ-024 Full and empty decisions SHALL use FIFO state at the start of the accept cycle; a same-cycle host pop or push SHALL NOT be bypassed.
REQ-025 The host interfaces SHALL use a valid/ready handshake: a transfer occurs when both are high.
REQ-026 host_out_valid SHALL equal TX not empty, and host_out_data SHALL be the TX head entry.
REQ-027 host_in_ready SHALL equal RX not full.
REQ-028 A simultaneous push and pop on one FIFO SHALL both take effect, leaving its count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and counts SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-030 The response stage SHALL be a two-state FSM: IDLE (no response pending) and RESP (response register valid); a valid non-NOP command moves it to RESP, otherwise to IDLE, from either state.

Reset
REQ-031 While reset=1 at a clock edge, both FIFOs SHALL empty, the FSM SHALL enter IDLE, and the outputs SHALL be from_peripheral=00, from_peripheral_data=0, from_peripheral_valid=0, host_out_valid=0 and host_in_ready=1.
REQ-032 A command accepted in the cycle reset asserts, or pending at that time, SHALL be dropped with no response.
REQ-033 FIFO storage contents SHALL NOT require reset.

Structure
REQ-034 Command codes, response codes and STATUS bit positions SHALL be defined as constants in the shared processor macros/package header.
REQ-035 Both FIFOs SHALL be instances of one sub-module, sync_fifo (parameters DATA_WIDTH, FIFO_DEPTH), exposing push, pop, full, empty and count.

Verification
REQ-036 Reset, then WRITE 0xDEADBEEF -> next cycle ACK/0 with valid high one cycle; host_out_valid=1, host_out_data=0xDEADBEEF.
REQ-037 Five WRITEs with host_out_ready=0 and FIFO_DEPTH=4 -> four ACKs then one ERROR; TX count=4; draining yields the four words in order.
REQ-038 READ on empty RX -> ERROR/0; then host pushes 0x11 and 0x22 and two READs follow -> DATA 0x11, then DATA 0x22.
REQ-039 Two TX entries and one RX entry, then STATUS -> DATA 0x00000102; STATUS on an empty block -> DATA 0x00020000.
REQ-040 TX full, and in one cycle host pops while core WRITEs -> ERROR, with TX count 3 afterwards.
REQ-041 Reset asserted the cycle after a READ is accepted -> no response is seen, from_peripheral_valid=0, and both FIFOs are empty.
